mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the fetch stage
// and the memory (load/store) stage of the pipeline.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   if_req_i, if_addr_i    fetch read request and address
//   mem_req_i, mem_we_i    data access request, 1 = store / 0 = load
//   mem_be_i               store byte enables
//   mem_addr_i             data access address
//   mem_wdata_i            store data
//   ex_stall_i             execute stage busy; holds served flags
//   flush_i                pipeline redirect; the current fetch is dead
//   if_rdata_o             registered fetch data (held until next fetch)
//   mem_rdata_o            registered load data (held until next load)
//   if_stall_o             fetch request not yet served
//   mem_stall_o            data request not yet served
//   bus_req_o .. wdata_o   registered bus command, stable while bus_req_o
//   bus_ack_i, bus_rdata_i bus completion and read data
//   bus_err_o              one-cycle pulse when a wait times out
//
// TIMEOUT: wait cycles before a forced completion (0 disables).

module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        ex_stall_i,
    input  logic        flush_i,
    output logic [31:0] if_rdata_o,
    output logic [31:0] mem_rdata_o,
    output logic        if_stall_o,
    output logic        mem_stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        MEM_WAIT
    } state_t;

    localparam logic [8:0] TMO = 9'(TIMEOUT);

    state_t      state;
    state_t      state_n;

    logic [7:0]  cnt;
    logic [7:0]  cnt_n;
    logic        if_served;
    logic        if_served_n;
    logic        mem_served;
    logic        mem_served_n;
    logic        discard;
    logic        discard_n;

    logic        bus_req_n;
    logic        bus_we_n;
    logic [3:0]  bus_be_n;
    logic [31:0] bus_addr_n;
    logic [31:0] bus_wdata_n;
    logic [31:0] if_rdata_n;
    logic [31:0] mem_rdata_n;
    logic        bus_err_n;

    logic        if_pend;
    logic        mem_pend;
    logic        advance;
    logic        waiting;
    logic        timeout_hit;
    logic        done;
    logic [31:0] resp_data;

    assign if_pend     = if_req_i & ~if_served;
    assign mem_pend    = mem_req_i & ~mem_served;
    assign if_stall_o  = if_pend;
    assign mem_stall_o = mem_pend;
    assign advance     = ~if_stall_o & ~mem_stall_o & ~ex_stall_i;

    assign waiting = (state != IDLE);

    // cnt counts completed wait cycles, so the wait cycle in which
    // cnt + 1 reaches TIMEOUT is the last one allowed.
    assign timeout_hit = waiting && (TIMEOUT != 0)
                      && (({1'b0, cnt} + 9'd1) == TMO);

    // An ack always wins over a coincident timeout.
    assign done      = waiting & (bus_ack_i | timeout_hit);
    assign resp_data = bus_ack_i ? bus_rdata_i : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        if_served_n  = if_served;
        mem_served_n = mem_served;
        discard_n    = discard;
        bus_req_n    = bus_req_o;
        bus_we_n     = bus_we_o;
        bus_be_n     = bus_be_o;
        bus_addr_n   = bus_addr_o;
        bus_wdata_n  = bus_wdata_o;
        if_rdata_n   = if_rdata_o;
        mem_rdata_n  = mem_rdata_o;
        bus_err_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (mem_pend) begin
                    state_n     = MEM_WAIT;
                    cnt_n       = 8'd0;
                    bus_req_n   = 1'b1;
                    bus_we_n    = mem_we_i;
                    bus_be_n    = mem_be_i;
                    bus_addr_n  = mem_addr_i;
                    bus_wdata_n = mem_wdata_i;
                end else if (if_pend) begin
                    state_n     = IF_WAIT;
                    cnt_n       = 8'd0;
                    bus_req_n   = 1'b1;
                    bus_we_n    = 1'b0;
                    bus_be_n    = 4'hF;
                    bus_addr_n  = if_addr_i;
                    bus_wdata_n = 32'h0;
                end
            end

            IF_WAIT: begin
                if (done) begin
                    state_n   = IDLE;
                    bus_req_n = 1'b0;
                    bus_err_n = ~bus_ack_i;
                    discard_n = 1'b0;
                    // A redirect before or with the ack kills the data.
                    if (!discard && !flush_i) begin
                        if_rdata_n  = resp_data;
                        if_served_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                    if (flush_i) begin
                        discard_n = 1'b1;
                    end
                end
            end

            MEM_WAIT: begin
                if (done) begin
                    state_n      = IDLE;
                    bus_req_n    = 1'b0;
                    bus_err_n    = ~bus_ack_i;
                    mem_served_n = 1'b1;
                    if (!bus_we_o) begin
                        mem_rdata_n = resp_data;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            default: begin
                state_n   = IDLE;
                bus_req_n = 1'b0;
            end
        endcase

        if (advance) begin
            if_served_n  = 1'b0;
            mem_served_n = 1'b0;
        end

        if (flush_i) begin
            if_served_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= 8'd0;
            if_served   <= 1'b0;
            mem_served  <= 1'b0;
            discard     <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_be_o    <= 4'h0;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
            if_rdata_o  <= 32'h0;
            mem_rdata_o <= 32'h0;
            bus_err_o   <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            if_served   <= if_served_n;
            mem_served  <= mem_served_n;
            discard     <= discard_n;
            bus_req_o   <= bus_req_n;
            bus_we_o    <= bus_we_n;
            bus_be_o    <= bus_be_n;
            bus_addr_o  <= bus_addr_n;
            bus_wdata_o <= bus_wdata_n;
            if_rdata_o  <= if_rdata_n;
            mem_rdata_o <= mem_rdata_n;
            bus_err_o   <= bus_err_n;
        end
    end

endmodule
